// File: rtl/cla_add_stage.sv
// cla_add_stage: two-stage handshaked add/sub around a 64-bit carry-lookahead adder.
// Carry and the all-zero flag chain across beats for multi-word operations.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gg,
  output logic       pg
);
  logic [3:0] g, p, c;
  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign s    = p ^ c;
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg   = &p;
endmodule

module cla_64bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] s,
  output logic        cout
);
  localparam int NGRP = 16;
  logic [NGRP:0]   gc;
  logic [NGRP-1:0] gg, pg;

  assign gc[0] = cin;
  // group carries from each nibble's generate/propagate pair
  for (genvar i = 0; i < NGRP; i++) begin : g_grp
    cla4 u_cla4 (
      .a  (a[4*i +: 4]),
      .b  (b[4*i +: 4]),
      .cin(gc[i]),
      .s  (s[4*i +: 4]),
      .gg (gg[i]),
      .pg (pg[i])
    );
    assign gc[i+1] = gg[i] | (pg[i] & gc[i]);
  end
  assign cout = gc[NGRP];
endmodule

module cla_add_stage #(
  parameter int WIDTH   = 64,
  parameter int ZERO_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_last,
  output logic             busy
);
  if (WIDTH != 64) begin : g_width_chk
    $error("cla_add_stage: WIDTH must be 64");
  end

  localparam logic ZE = (ZERO_EN != 0);

  logic             s1_valid, s2_valid, s2_free, advance, in_xfer;
  logic [WIDTH-1:0] a1, b1, sum;
  logic             sub1, first1, last1;
  logic             carry_q, zero_q;
  logic             cin, cout, ovf, word_zero, zero;

  assign s2_free  = !s2_valid | out_ready;
  assign advance  = s1_valid & s2_free;
  assign in_ready = !s1_valid | s2_free;
  assign in_xfer  = in_valid & in_ready;

  // a first beat starts a fresh chain: cin is the subtract +1
  assign cin = first1 ? sub1 : carry_q;

  cla_64bit u_cla (
    .a   (a1),
    .b   (b1),
    .cin (cin),
    .s   (sum),
    .cout(cout)
  );

  assign ovf       = (a1[WIDTH-1] == b1[WIDTH-1]) & (sum[WIDTH-1] != a1[WIDTH-1]);
  assign word_zero = (sum == '0);
  assign zero      = ZE & word_zero & (first1 | zero_q);

  assign out_valid = s2_valid;
  assign busy      = s1_valid | s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      a1       <= '0;
      b1       <= '0;
      sub1     <= 1'b0;
      first1   <= 1'b0;
      last1    <= 1'b0;
      s2_valid <= 1'b0;
      out_s    <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
      out_last <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      if (in_xfer) begin
        s1_valid <= 1'b1;
        a1       <= in_a;
        b1       <= in_b ^ {WIDTH{in_sub}};
        sub1     <= in_sub;
        first1   <= in_first;
        last1    <= in_last;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
      // S2 only loads on advance, so a stalled result holds its value
      if (advance) begin
        s2_valid <= 1'b1;
        out_s    <= sum;
        out_cout <= cout;
        out_ovf  <= ovf;
        out_zero <= zero;
        out_last <= last1;
        carry_q  <= cout;
        zero_q   <= zero;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cla_add_stage.sv
// Self-checking bench for cla_add_stage: directed vector table, back-pressure and
// reset sequences, and randomized traffic scored against a multi-word arithmetic model.

module tb_cla_add_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_sub = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [63:0] in_a = '0, in_b = '0, out_s;
  logic        out_valid, out_ready = 1'b0, out_cout, out_ovf, out_zero, out_last, busy;

  always #5 clk = ~clk;

  cla_add_stage #(.WIDTH(64), .ZERO_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_cout(out_cout),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_last(out_last), .busy(busy)
  );

  typedef struct packed {
    logic [63:0] s;
    logic        cout, ovf, zero, last;
  } res_t;

  typedef struct {
    logic [63:0] a, b;
    logic        sub, first, last;
    res_t        exp;
  } vec_t;

  int   errors = 0, checks = 0, delivered = 0;
  res_t sbq[$];
  logic m_carry = 1'b0, m_zero = 1'b1;

  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = -SMAX - 66'sd1;

  function automatic res_t act_res();
    return '{s: out_s, cout: out_cout, ovf: out_ovf, zero: out_zero, last: out_last};
  endfunction

  // Reference: word-wise arithmetic with an explicit carry/zero chain
  function automatic res_t model(input logic [63:0] a, b, input logic sub, first, last);
    res_t r;
    logic [63:0] bb;
    logic cin;
    logic [64:0] full;
    logic signed [65:0] ss;
    bb   = sub ? ~b : b;
    cin  = first ? sub : m_carry;
    full = {1'b0, a} + {1'b0, bb} + {64'd0, cin};
    ss   = $signed({{2{a[63]}}, a}) + $signed({{2{bb[63]}}, bb}) + $signed({65'd0, cin});
    r.s    = full[63:0];
    r.cout = full[64];
    r.ovf  = (ss > SMAX) || (ss < SMIN);
    r.zero = (full[63:0] == 64'd0) && (first || m_zero);
    r.last = last;
    m_carry = r.cout;
    m_zero  = r.zero;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every handshake, every test
  always @(negedge clk) begin
    if (!rst_n) begin
      sbq.delete();
      m_carry = 1'b0;
      m_zero  = 1'b1;
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %h want none", act_res());
        end else begin
          res_t e;
          e = sbq.pop_front();
          delivered++;
          if (act_res() !== e) begin
            errors++;
            $display("FAIL sb_result: got %h want %h", act_res(), e);
          end
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(in_a, in_b, in_sub, in_first, in_last));
    end
  end

  function automatic vec_t mk(input logic [63:0] a, b, input logic sub, first, last,
                              input logic [63:0] s, input logic co, ov, z);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.first = first; v.last = last;
    v.exp = '{s: s, cout: co, ovf: ov, zero: z, last: last};
    return v;
  endfunction

  // Caller is at posedge+1 with S1 empty
  task automatic run_beat(input vec_t v, input string nm);
    in_a = v.a; in_b = v.b; in_sub = v.sub; in_first = v.first; in_last = v.last;
    in_valid = 1'b1; out_ready = 1'b1;
    chk({nm, "_rdy"}, 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk(nm, {out_valid, act_res()}, {1'b1, v.exp});
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom % 8)
      0:       return '1;
      1:       return '0;
      2:       return 64'($urandom % 4);
      3:       return {1'b0, {63{1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  int op_len = 0, op_idx = 0;
  logic op_sub = 1'b0;

  task automatic next_beat();
    if (op_idx >= op_len) begin
      op_len = $urandom_range(1, 3);
      op_idx = 0;
      op_sub = 1'($urandom % 2);
    end
    in_a = rnd64(); in_b = rnd64(); in_sub = op_sub;
    in_first = (op_idx == 0);
    in_last  = (op_idx == op_len - 1);
    op_idx++;
  endtask

  vec_t        vt[10];
  logic [63:0] bp_a[4], bp_b[4];

  initial begin
    vt[0] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1, 1, 64'd0, 1, 0, 1);
    vt[1] = mk(64'd5, 64'd7, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0);
    vt[2] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 1, 0, 64'd0, 1, 0, 1);
    vt[3] = mk(64'd1, 64'd0, 0, 0, 1, 64'd2, 0, 0, 0);
    vt[4] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 1, 1, 64'h8000_0000_0000_0000, 0, 1, 0);
    vt[5] = mk(64'd7, 64'd7, 1, 1, 1, 64'd0, 1, 0, 1);
    vt[6] = mk(64'd0, 64'd1, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    vt[7] = mk(64'd0, 64'd0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    vt[8] = mk(64'd0, 64'd0, 0, 1, 0, 64'd0, 0, 0, 1);
    vt[9] = mk(64'd0, 64'd0, 0, 0, 1, 64'd0, 0, 0, 1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, busy, in_ready, act_res()}, {3'b001, 68'd0});
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) run_beat(vt[i], $sformatf("vec%0d", i));
    begin
      vec_t v8;
      v8 = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 1, 1, 64'd0, 1, 1, 1);
      run_beat(v8, "neg_ovf");
    end
    @(posedge clk); #1;

    // back-pressure: 4 back-to-back beats, out_ready low for 5 cycles
    begin
      int   idx, d0;
      logic acc, have;
      res_t snap;
      idx = 0; have = 1'b0; snap = '0;
      d0 = delivered;
      foreach (bp_a[i]) begin bp_a[i] = rnd64(); bp_b[i] = rnd64(); end
      out_ready = 1'b0;
      in_a = bp_a[0]; in_b = bp_b[0]; in_sub = 1'b0; in_first = 1'b1; in_last = 1'b1;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk); acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) begin
          idx++;
          if (idx < 4) begin in_a = bp_a[idx]; in_b = bp_b[idx]; in_sub = idx[0]; end
          else in_valid = 1'b0;
        end
        if (out_valid) begin
          if (!have) begin snap = act_res(); have = 1'b1; end
          else chk("bp_stable", 128'(act_res()), 128'(snap));
        end
      end
      chk("bp_accepted", 128'(idx), 128'(2));
      chk("bp_stall", {out_valid, in_ready, busy}, 128'(3'b101));
      out_ready = 1'b1;
      for (int c = 0; c < 40 && (idx < 4 || busy); c++) begin
        @(negedge clk); acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) begin
          idx++;
          if (idx < 4) begin in_a = bp_a[idx]; in_b = bp_b[idx]; in_sub = idx[0]; end
          else in_valid = 1'b0;
        end
      end
      chk("bp_delivered", 128'(delivered - d0), 128'(4));
    end

    // reset mid-chain with S1 and S2 full
    out_ready = 1'b0;
    in_a = 64'hFFFF_FFFF_FFFF_FFFF; in_b = 64'd1; in_sub = 1'b0; in_first = 1'b1; in_last = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 64'd3; in_b = 64'd4; in_first = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_pre_full", {out_valid, busy, in_ready}, 128'(3'b110));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", {out_valid, busy}, 128'(2'b00));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_beat(mk(64'd5, 64'd6, 0, 0, 1, 64'd11, 0, 0, 0), "rst_nonfirst");
    run_beat(mk(64'd10, 64'd3, 1, 1, 1, 64'd7, 1, 0, 0), "rst_first_sub");
    @(posedge clk); #1;

    // randomized traffic with random back-pressure
    begin
      int   sent;
      logic acc;
      sent = 0;
      next_beat();
      for (int c = 0; c < 4000 && sent < 400; c++) begin
        in_valid  = ($urandom % 4) != 0;
        out_ready = ($urandom % 4) != 0;
        @(negedge clk); acc = in_valid && in_ready;
        @(posedge clk); #1;
        if (acc) begin sent++; next_beat(); end
      end
      in_valid = 1'b0;
      chk("rand_sent", 128'(sent), 128'(400));
      out_ready = 1'b1;
      for (int c = 0; c < 50 && (busy || sbq.size() != 0); c++) @(posedge clk);
      #1;
      chk("drain", {busy, 32'(sbq.size())}, 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
